// File: rtl/bf16_pkg.sv
// Shared bfloat16 types and constants for the bf16 datapath blocks.
package bf16_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] man;
  } bf16_t;

  localparam int         BF16_BIAS    = 127;
  localparam logic [7:0] BF16_EXP_MAX = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    CLASSIFY,
    SHIFT,
    ROUND,
    HOLD
  } cvt_state_t;

  // Bit positions inside the {invalid, overflow, inexact} flag vector
  localparam int FLAG_INVALID  = 2;
  localparam int FLAG_OVERFLOW = 1;
  localparam int FLAG_INEXACT  = 0;

endpackage

// File: rtl/bf16_classify.sv
// Combinational bfloat16 operand classification: specials, unbiased exponent,
// mantissa-nonzero.
module bf16_classify
  import bf16_pkg::*;
(
  input  bf16_t              op,
  output logic               is_nan,
  output logic               is_inf,
  output logic               is_zero_sub,
  output logic signed [8:0]  exp_unb,
  output logic               man_nz
);

  assign man_nz      = |op.man;
  assign is_nan      = (op.exp == BF16_EXP_MAX) && man_nz;
  assign is_inf      = (op.exp == BF16_EXP_MAX) && !man_nz;
  assign is_zero_sub = (op.exp == 8'h00);
  assign exp_unb     = $signed({1'b0, op.exp}) - $signed(9'(BF16_BIAS));

endmodule

// File: rtl/bfloat16_to_int.sv
// Iterative bfloat16 -> signed integer converter: RNE rounding, saturation,
// {invalid, overflow, inexact} flags, one bit of shift per cycle.
module bfloat16_to_int
  import bf16_pkg::*;
#(
  parameter int INT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] out_data,
  output logic [2:0]       out_flags,
  output logic             busy
);

  localparam int ACC_W = INT_W + 8;
  localparam int CNT_W = $clog2(INT_W);

  localparam logic [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic [INT_W:0]   POS_LIM = {2'b00, {(INT_W-1){1'b1}}};
  localparam logic [INT_W:0]   NEG_LIM = {2'b01, {(INT_W-1){1'b0}}};

  cvt_state_t state, state_next;

  bf16_t             op;
  logic [ACC_W-1:0]  acc;
  logic              sticky;
  logic [CNT_W-1:0]  cnt;
  logic              shift_right;

  logic              is_nan, is_inf, is_zero_sub, man_nz;
  logic signed [8:0] exp_unb;

  bf16_classify u_classify (
    .op          (op),
    .is_nan      (is_nan),
    .is_inf      (is_inf),
    .is_zero_sub (is_zero_sub),
    .exp_unb     (exp_unb),
    .man_nz      (man_nz)
  );

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. in_ready is high only in IDLE; out_valid is high only in HOLD,
  // where out_data/out_flags stay stable until out_ready is seen.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);

  logic             too_small, too_big, special;
  logic [CNT_W-1:0] shift_n;
  logic [INT_W-1:0] sat_val;
  logic [INT_W-1:0] spec_data;
  logic [2:0]       spec_flags;

  assign too_small = exp_unb < -9'sd1;
  assign too_big   = exp_unb > $signed(9'(INT_W - 1));
  assign special   = is_nan | is_inf | is_zero_sub | too_small | too_big;
  assign shift_n   = exp_unb[8] ? CNT_W'(1) : exp_unb[CNT_W-1:0];
  assign sat_val   = op.sign ? INT_MIN : INT_MAX;

  always_comb begin
    spec_data  = '0;
    spec_flags = '0;
    if (is_nan) begin
      spec_flags[FLAG_INVALID] = 1'b1;
    end else if (is_inf) begin
      spec_data                 = sat_val;
      spec_flags[FLAG_OVERFLOW] = 1'b1;
    end else if (is_zero_sub) begin
      spec_flags[FLAG_INEXACT] = man_nz;
    end else if (too_small) begin
      spec_flags[FLAG_INEXACT] = 1'b1;
    end else if (too_big) begin
      spec_data                 = sat_val;
      spec_flags[FLAG_OVERFLOW] = 1'b1;
    end
  end

  // Round-to-nearest-even on the integer field, then saturate by sign
  logic [INT_W-1:0] int_f;
  logic             g, s, inc, sat;
  logic [INT_W:0]   mag;
  logic [INT_W-1:0] rnd_data;
  logic [2:0]       rnd_flags;

  always_comb begin
    int_f     = acc[ACC_W-1:8];
    g         = acc[7];
    s         = (|acc[6:0]) | sticky;
    inc       = g & (s | int_f[0]);
    mag       = {1'b0, int_f} + (INT_W+1)'(inc);
    sat       = op.sign ? (mag > NEG_LIM) : (mag > POS_LIM);
    rnd_flags = '0;
    if (sat) begin
      rnd_data                 = sat_val;
      rnd_flags[FLAG_OVERFLOW] = 1'b1;
    end else begin
      rnd_data                = op.sign ? -mag[INT_W-1:0] : mag[INT_W-1:0];
      rnd_flags[FLAG_INEXACT] = g | s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (in_valid) state_next = CLASSIFY;
      CLASSIFY: begin
        if (special)           state_next = HOLD;
        else if (shift_n == 0) state_next = ROUND;
        else                   state_next = SHIFT;
      end
      SHIFT:    if (cnt == CNT_W'(1)) state_next = ROUND;
      ROUND:    state_next = HOLD;
      HOLD:     if (out_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op          <= '0;
      acc         <= '0;
      sticky      <= 1'b0;
      cnt         <= '0;
      shift_right <= 1'b0;
      out_data    <= '0;
      out_flags   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) op <= in_data;
        CLASSIFY: begin
          if (special) begin
            out_data  <= spec_data;
            out_flags <= spec_flags;
          end
          // Hidden one lands on bit 8 so the accumulator reads as 1.m
          acc         <= {{(INT_W-1){1'b0}}, 1'b1, op.man, 1'b0};
          sticky      <= 1'b0;
          cnt         <= shift_n;
          shift_right <= exp_unb[8];
        end
        SHIFT: begin
          if (shift_right) begin
            acc    <= acc >> 1;
            sticky <= sticky | acc[0];
          end else begin
            acc <= acc << 1;
          end
          cnt <= cnt - CNT_W'(1);
        end
        ROUND: begin
          out_data  <= rnd_data;
          out_flags <= rnd_flags;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bfloat16_to_int.md
Name: bfloat16_to_int

Overview:
- Sequential converter from a bfloat16 value to a signed two's-complement integer.
- Sits downstream of the bfloat16 add/sub and MAC datapath. It returns results to the integer domain.
- Round-to-nearest-even, saturating, with exception flags.
- Iterative shifter moves one bit per cycle. Valid/ready handshake on both sides; one conversion in flight at a time.

Parameters:
- INT_W, 16, width of the integer result (two's complement, at least 9).

Ports:
- clk  input  1  clock, all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  in_data is valid
- in_ready  output  1  converter can accept an operand
- in_data  input  16  bfloat16 operand: [15] sign, [14:7] exponent, [6:0] mantissa
- out_valid  output  1  out_data and out_flags are valid
- out_ready  input  1  consumer accepts the result
- out_data  output  INT_W  converted integer
- out_flags  output  3  {invalid, overflow, inexact}
- busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: clears state to IDLE and sets out_valid=0, out_data=0, out_flags=0, busy=0, in_ready=1. Takes effect immediately, including mid-conversion; an in-flight operand is discarded.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready at edge T, capture the operand and go to CLASSIFY.
  - CLASSIFY: occupies cycle T+1. Let e=in_data[14:7], E=e-127.
  - SHIFT: n cycles.
  - ROUND: 1 cycle.
  - HOLD: out_valid=1, outputs stable. On out_valid&out_ready go to IDLE; in_ready rises the following cycle.
- Classify rules (special cases go straight to HOLD, so out_valid is asserted at T+2):
  - e=255, mantissa≠0 (NaN): out 0, flags 100.
  - e=255, mantissa=0 (±Inf): saturate to max or min by sign, flags 010.
  - e=0: subnormal inputs flush to zero. Out 0; flags 001 if mantissa≠0, else 000 (-0 gives 0).
  - E<-1: out 0, flags 001.
  - E>INT_W-1: saturate by sign, flags 010.
  - Otherwise: load the accumulator and go to SHIFT with n=|E|. If n=0, go to ROUND.
- Accumulator: unsigned, INT_W integer bits plus 8 fraction bits, and a sticky bit.
  - Load {1,mantissa} aligned so the value is 1.m.
  - E≥0: shift left one bit per cycle.
  - E=-1: shift right once; the bit shifted out ORs into sticky.
- Round (RNE), in ROUND:
  - int = acc integer field, g = acc[7], s = |acc[6:0] | sticky.
  - inc = g & (s | int[0]); mag = int + inc, INT_W+1 bits wide.
  - inexact = g|s.
  - Positive: mag>2^(INT_W-1)-1 saturates to 2^(INT_W-1)-1.
  - Negative: mag>2^(INT_W-1) saturates to -2^(INT_W-1).
  - On saturation, flags = 010 (inexact cleared). Otherwise negate mag if sign=1.
- Latency: shift path out_valid is asserted at T+3+n.
- Back-pressure: HOLD holds indefinitely. in_ready=0 in every state except IDLE. in_valid while not ready is ignored (the operand is not captured).
- busy is high in every state except IDLE.

Decomposition:
- Shared package bf16_pkg:
  - bf16_t packed struct {sign, exp[7:0], man[6:0]}.
  - Constants BF16_BIAS=127, BF16_EXP_MAX=8'hFF.
  - State enum cvt_state_t {IDLE, CLASSIFY, SHIFT, ROUND, HOLD}.
  - Flag bit indices.
- One natural sub-module, bf16_classify: combinational.
  - Inputs: bf16_t. Outputs: is_nan, is_inf, is_zero_sub, unbiased E, mantissa-nonzero.
  - Reusable by the add/sub special-case logic.
- FSM, accumulator and rounding stay in the top level.

Test Plan:
- 0x3F80 (1.0) → out 1, flags 000, out_valid at T+3. 0x4049 (3.140625) → 3, flags 001, out_valid at T+4.
- RNE ties:
  - 0x3FC0 (1.5) → 2.
  - 0x4020 (2.5) → 2.
  - 0x3F00 (0.5) → 0.
  - 0xBFC0 (-1.5) → -2 (0xFFFE).
  - All flags 001. 0x3F40 (0.75) → 1.
- Range edges:
  - 0xC700 (-32768) → 0x8000, flags 000, T+18.
  - 0x4700 (+32768) → 0x7FFF, flags 010.
  - 0x4780 (65536) → 0x7FFF, flags 010, T+2.
- Specials:
  - 0x7FC0 NaN → 0, flags 100, T+2.
  - 0xFF80 -Inf → 0x8000, flags 010.
  - 0x8000 → 0, flags 000.
  - 0x0001 → 0, flags 001.
  - 0x3E80 (0.25) → 0, flags 001.
- Back-pressure: hold out_ready=0 for 5 cycles → out_valid, out_data and flags stable, in_ready=0. A second in_valid during the stall is not captured; it is accepted only after the out handshake.
- Reset: assert rst during SHIFT of 0x4700 → out_valid=0 and busy=0 immediately. After release, in_ready=1, and a new operand 0x3F80 yields 1.
